k6502_trace: RTL and testbench

//   Synthesizable execution tracer downstream of the k6502 core. Snoops the CPU bus and debug ports and

---
 rtl/k6502_trace_pkg.sv | 30 +++
 rtl/k6502_trace_fifo.sv | 45 ++++
 rtl/k6502_trace.sv | 106 ++++++++++
 tb/tb_k6502_trace.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/k6502_trace_pkg.sv
// Shared record kinds, payload layouts and helpers for the k6502 execution tracer.
package k6502_trace_pkg;

  localparam int TR_PAYLOAD_W = 56;

  localparam logic [1:0] TR_FETCH = 2'b00;
  localparam logic [1:0] TR_WRITE = 2'b01;

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  ir;
    logic [7:0]  sr;
    logic [7:0]  a;
    logic [7:0]  x;
    logic [7:0]  y;
  } fetch_pl_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic [31:0] rsvd;
  } write_pl_t;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/k6502_trace_fifo.sv
// Single-clock trace FIFO; head is shown combinationally and reads as zero when empty.
module k6502_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  output logic          full,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         wr_en, rd_en;

  // a pop frees the slot this cycle, so a full FIFO still accepts a push
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (level == (AW+1)'(DEPTH));
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/k6502_trace.sv
// k6502 execution tracer: fetch (and, with K6502_TRACE_WRITE_EN, write) records into a FIFO,
// with cycle stamps, drop counting and sticky halt on a write to HALT_ADDR.
module k6502_trace
  import k6502_trace_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter int          CYC_W     = 16,
  parameter logic [15:0] HALT_ADDR = 16'hDEAD,
  localparam int         TR_W      = 2 + CYC_W + TR_PAYLOAD_W,
  localparam int         LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [15:0]      cpu_a,
  input  logic [7:0]       cpu_d,
  input  logic             cpu_rw,
  input  logic             cpu_sync,
  input  logic [15:0]      dbg_pc,
  input  logic [7:0]       dbg_ir,
  input  logic [7:0]       dbg_sr,
  input  logic [7:0]       dbg_ra,
  input  logic [7:0]       dbg_rx,
  input  logic [7:0]       dbg_ry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TR_W-1:0]  out_data,
  output logic [LVL_W-1:0] level,
  output logic [7:0]       drop_cnt,
  output logic             halt
);

  logic [CYC_W-1:0] cyc, pend_cyc;
  logic             sync_q, fetch_pend, halt_q;
  logic [7:0]       drop_q;
  logic             cap_en, fetch_det, wr_evt, halt_hit;
  logic             push, full, empty;
  logic [TR_W-1:0]  push_data;
  logic [1:0]       n_drop;
  fetch_pl_t        f_pl;
  write_pl_t        w_pl;

  assign cap_en    = enable & ~halt_q;
  assign fetch_det = cpu_sync & ~sync_q & cap_en;
  assign halt_hit  = cpu_rw & (cpu_a == HALT_ADDR);

`ifdef K6502_TRACE_WRITE_EN
  assign wr_evt = cpu_rw & cap_en;
`else
  assign wr_evt = 1'b0;
`endif

  // core registers settle one edge after sync, so fetch payload comes from the sample edge
  assign f_pl = '{pc: dbg_pc, ir: dbg_ir, sr: dbg_sr, a: dbg_ra, x: dbg_rx, y: dbg_ry};
  assign w_pl = '{addr: cpu_a, data: cpu_d, rsvd: 32'h0};

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    n_drop    = 2'd0;
    if (fetch_pend) begin
      push      = 1'b1;
      push_data = {TR_FETCH, pend_cyc, f_pl};
      if (wr_evt) n_drop = 2'd1;
    end else if (wr_evt) begin
      push      = 1'b1;
      push_data = {TR_WRITE, cyc, w_pl};
    end
    if (push & full & ~out_ready) n_drop = n_drop + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc        <= '0;
      pend_cyc   <= '0;
      sync_q     <= 1'b0;
      fetch_pend <= 1'b0;
      halt_q     <= 1'b0;
      drop_q     <= 8'h00;
    end else begin
      cyc        <= cyc + 1'b1;
      sync_q     <= cpu_sync;
      fetch_pend <= fetch_det;
      if (fetch_det) pend_cyc <= cyc;
      if (halt_hit) halt_q <= 1'b1;
      drop_q     <= sat_add8(drop_q, n_drop);
    end
  end

  k6502_trace_fifo #(.DEPTH(DEPTH), .W(TR_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_data),
    .full  (full),
    .pop   (out_ready),
    .dout  (out_data),
    .empty (empty),
    .level (level)
  );

  assign out_valid = ~empty;
  assign drop_cnt  = drop_q;
  assign halt      = halt_q;

endmodule

// File: tb/tb_k6502_trace.sv
// Self-checking bench for k6502_trace: directed scenarios plus random traffic against a queue model.
module tb_k6502_trace;

  localparam int DEPTH = 16;
  localparam int TR_W  = 74;
`ifdef K6502_TRACE_WRITE_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, enable, cpu_rw, cpu_sync, out_ready;
  logic [15:0] cpu_a, dbg_pc;
  logic [7:0]  cpu_d, dbg_ir, dbg_sr, dbg_ra, dbg_rx, dbg_ry;
  logic        out_valid, halt;
  logic [TR_W-1:0] out_data;
  logic [4:0]  level;
  logic [7:0]  drop_cnt;

  k6502_trace #(.DEPTH(DEPTH), .CYC_W(16), .HALT_ADDR(16'hDEAD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cpu_a(cpu_a), .cpu_d(cpu_d),
    .cpu_rw(cpu_rw), .cpu_sync(cpu_sync), .dbg_pc(dbg_pc), .dbg_ir(dbg_ir),
    .dbg_sr(dbg_sr), .dbg_ra(dbg_ra), .dbg_rx(dbg_rx), .dbg_ry(dbg_ry),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .drop_cnt(drop_cnt), .halt(halt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: record queue plus the few bits of history the rules depend on
  logic [TR_W-1:0] q[$];
  int m_cyc = 0, m_pcyc = 0, m_drop = 0;
  bit m_syncq = 0, m_pend = 0, m_halt = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [TR_W-1:0] rec;
    bit push, cap, det, wr;
    int nd;
    if (!rst_n) begin
      q.delete();
      m_cyc = 0; m_pcyc = 0; m_drop = 0;
      m_syncq = 0; m_pend = 0; m_halt = 0;
    end else begin
      cap = enable && !m_halt;
      det = cpu_sync && !m_syncq && cap;
      wr  = WEN && cpu_rw && cap;
      push = 0; nd = 0; rec = '0;
      if (m_pend) begin
        push = 1;
        rec = {2'b00, 16'(m_pcyc), dbg_pc, dbg_ir, dbg_sr, dbg_ra, dbg_rx, dbg_ry};
        if (wr) nd++;
      end else if (wr) begin
        push = 1;
        rec = {2'b01, 16'(m_cyc), cpu_a, cpu_d, 32'h0};
      end
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) q.push_back(rec);
        else nd++;
      end
      m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
      if (cpu_rw && cpu_a == 16'hDEAD) m_halt = 1;
      m_pend  = det;
      m_pcyc  = m_cyc;
      m_syncq = cpu_sync;
      m_cyc   = (m_cyc + 1) % 65536;
    end
    @(posedge clk); #1;
    chk("valid", out_valid, q.size() != 0);
    chk("level", level, q.size());
    chk("data", out_data, (q.size() != 0) ? q[0] : '0);
    chk("drop", drop_cnt, m_drop);
    chk("halt", halt, m_halt);
  endtask

  task automatic fetch1();
    cpu_sync = 1'b1; tick();
    cpu_sync = 1'b0; tick();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 2*DEPTH && out_valid; i++) tick();
    chk("drain_empty", out_valid, 1'b0);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int prev;
    rst_n = 1'b0; enable = 1'b1; cpu_rw = 1'b0; cpu_sync = 1'b0; out_ready = 1'b0;
    cpu_a = 16'h0000; cpu_d = 8'h00;
    dbg_pc = 16'h8000; dbg_ir = 8'hA9; dbg_sr = 8'h24; dbg_ra = 8'h01; dbg_rx = 8'h02; dbg_ry = 8'h03;

    // 1: reset, single fetch
    repeat (4) tick();
    chk("rst_level", level, 0);
    chk("rst_data", out_data, 0);
    rst_n = 1'b1;
    fetch1();
    chk("t1_valid", out_valid, 1);
    chk("t1_kind", out_data[73:72], 2'b00);
    chk("t1_stamp", out_data[71:56], 16'd0);
    chk("t1_payload", out_data[55:0], 56'h8000A924010203);
    drain();

    // 2: overflow by three
    for (int i = 0; i < DEPTH + 3; i++) begin
      dbg_pc = 16'h1000 + 16'(i);
      fetch1();
    end
    chk("t2_level", level, DEPTH);
    chk("t2_drop", drop_cnt, 3);

    // 3: push and pop together while full
    cpu_sync = 1'b1; tick();
    cpu_sync = 1'b0; out_ready = 1'b1; tick();
    out_ready = 1'b0;
    chk("t3_level", level, DEPTH);
    chk("t3_drop", drop_cnt, 3);

    prev = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 2*DEPTH && out_valid; i++) begin
      chk("t2_order", int'(out_data[71:56]) > prev, 1'b1);
      prev = int'(out_data[71:56]);
      tick();
    end
    out_ready = 1'b0;
    chk("t2_drained", out_valid, 0);
    do_reset();

    // 5: fetch sample collides with a write
    cpu_sync = 1'b1; tick();
    cpu_sync = 1'b0; cpu_rw = 1'b1; cpu_a = 16'h0300; cpu_d = 8'h77; tick();
    cpu_rw = 1'b0; tick();
    chk("t5_drop", drop_cnt, WEN ? 1 : 0);
    chk("t5_level", level, 1);
    chk("t5_kind", out_data[73:72], 2'b00);
    drain();

    // 6: reset while holding five records
    repeat (5) fetch1();
    chk("t6_pre_level", level, 5);
    do_reset();
    chk("t6_valid", out_valid, 0);
    chk("t6_level", level, 0);
    chk("t6_drop", drop_cnt, 0);
    chk("t6_halt", halt, 0);

    // 4: writes, halt, then no further capture
    cpu_rw = 1'b1; cpu_a = 16'h0200; cpu_d = 8'h5A; tick();
    cpu_a = 16'hDEAD; cpu_d = 8'h00; tick();
    cpu_rw = 1'b0;
    repeat (3) fetch1();
    chk("t4_halt", halt, 1);
    chk("t4_level", level, WEN ? 2 : 0);
    if (WEN) begin
      chk("t4_w0", {out_data[73:72], out_data[55:0]}, {2'b01, 56'h02005A00000000});
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk("t4_w1", {out_data[73:72], out_data[55:0]}, {2'b01, 56'hDEAD0000000000});
    end
    drain();
    do_reset();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom % 300) != 0;
      enable    = ($urandom % 8) != 0;
      cpu_sync  = ($urandom % 3) == 0;
      cpu_rw    = ($urandom % 4) == 0;
      cpu_a     = (($urandom % 40) == 0) ? 16'hDEAD : 16'($urandom);
      cpu_d     = 8'($urandom);
      out_ready = ($urandom % 3) == 0;
      dbg_pc = 16'($urandom); dbg_ir = 8'($urandom); dbg_sr = 8'($urandom);
      dbg_ra = 8'($urandom);  dbg_rx = 8'($urandom); dbg_ry = 8'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
